// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce and one-cycle key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int unsigned SCAN_CYCLES     = 24000,
   parameter int unsigned DEBOUNCE_CYCLES = 480000,
   parameter int unsigned REPEAT_CYCLES   = 12000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned MaxSd  = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                    : DEBOUNCE_CYCLES;
   localparam int unsigned MaxCyc = (MaxSd > REPEAT_CYCLES) ? MaxSd : REPEAT_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

   localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);
   localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StScan, StDbPress, StHeld, StDbRel} state_e;

   state_e          state_q, state_d;
   logic [1:0]      c_q, c_d;
   logic [1:0]      r_q, r_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_inc;
   logic [3:0]      key_q, key_d;
   logic            kv_q, kv_d;
   logic [3:0]      row_m_q, row_s_q;
   logic [1:0]      low_row;
   logic            row_low;
   logic            rpt_fire;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         row_m_q <= 4'hF;
         row_s_q <= 4'hF;
      end else begin
         row_m_q <= row;
         row_s_q <= row_m_q;
      end
   end

   always_comb begin
      low_row = 2'd3;
      if (!row_s_q[0])      low_row = 2'd0;
      else if (!row_s_q[1]) low_row = 2'd1;
      else if (!row_s_q[2]) low_row = 2'd2;
   end

   assign row_low = ~row_s_q[r_q];
   assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [CntW-1:0] RptLast = CntW'(REPEAT_CYCLES - 1);

   logic [CntW-1:0] rpt_q, rpt_d;

   assign rpt_fire = (state_q == StHeld) && row_low && (rpt_q == RptLast);

   // Counts only across consecutive HELD cycles; any entry into or exit from HELD clears it.
   always_comb begin
      rpt_d = '0;
      if (state_q == StHeld && state_d == StHeld) begin
         if (rpt_fire)                       rpt_d = '0;
         else if (rpt_q == {CntW{1'b1}})     rpt_d = rpt_q;
         else                                rpt_d = rpt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) rpt_q <= '0;
      else          rpt_q <= rpt_d;
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      kv_d    = 1'b0;
      case (state_q)
         StScan: begin
            if (cnt_q == ScanLast) begin
               cnt_d = '0;
               if (row_s_q != 4'hF) begin
                  r_d     = low_row;
                  state_d = StDbPress;
               end else begin
                  c_d = c_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StDbPress: begin
            if (!row_low) begin
               state_d = StScan;
               cnt_d   = '0;
            end else if (cnt_q == DebLast) begin
               key_d   = key_code(r_q, c_q);
               kv_d    = 1'b1;
               cnt_d   = '0;
               state_d = StHeld;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StHeld: begin
            if (!row_low) begin
               cnt_d   = '0;
               state_d = StDbRel;
            end else if (rpt_fire) begin
               kv_d = 1'b1;
            end
         end
         StDbRel: begin
            if (row_low) begin
               state_d = StHeld;
            end else if (cnt_q == DebLast) begin
               cnt_d   = '0;
               c_d     = c_q + 2'd1;
               state_d = StScan;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = StScan;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StScan;
         c_q     <= 2'd0;
         r_q     <= 2'd0;
         cnt_q   <= '0;
         key_q   <= 4'h0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         kv_q    <= kv_d;
      end
   end

   assign col       = ~(4'b0001 << c_q);
   assign key       = key_q;
   assign key_valid = kv_q;
   assign key_held  = (state_q == StHeld) || (state_q == StDbRel);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, strobe scoreboard, vector table.
module tb_keypad_scanner;

   localparam int unsigned Scan = 8;
   localparam int unsigned Deb  = 16;
   localparam int unsigned Rep  = 32;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_held;
   logic [15:0] down = '0;  // pressed switches, index row*4+col

   always #5 clk = ~clk;

   // A pressed switch shorts its row to its column; only the low column pulls a row low.
   always_comb begin
      row = 4'hF;
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++)
            if (down[rr*4+cc] && !col[cc]) row[rr] = 1'b0;
   end

   keypad_scanner #(
      .SCAN_CYCLES    (Scan),
      .DEBOUNCE_CYCLES(Deb),
      .REPEAT_CYCLES  (Rep)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .row      (row),
      .col      (col),
      .key      (key),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   typedef struct {
      logic [3:0]  code;
      int unsigned cyc;
   } obs_t;

   typedef struct {
      int         r;
      int         c;
      logic [3:0] code;
   } vec_t;

   obs_t        obs_q[$];
   logic [3:0]  exp_q[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   vec_t        vecs[16];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (key_valid) obs_q.push_back('{code: key, cyc: cyc});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [3:0] col_of(input int c);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << c);
   endfunction

   // Waits for a fresh entry into column c.
   task automatic wait_col(input int c);
      int n;
      n = 0;
      while (col === col_of(c) && n < 200) begin @(negedge clk); n++; end
      while (col !== col_of(c) && n < 200) begin @(negedge clk); n++; end
      chk("wait_col within budget", n < 200, 1);
   endtask

   task automatic wait_kv(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (key_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("key_valid within budget", ok, 1);
   endtask

   task automatic wait_release(output int n);
      n = 0;
      while (key_held && n < 200) begin @(negedge clk); n++; end
      chk("key_held drop within budget", n < 200, 1);
   endtask

   task automatic drain(input string name);
      obs_t       o;
      logic [3:0] e;
      chk({name, " strobe count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() != 0 && exp_q.size() != 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({name, " strobe key"}, o.code, e);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      bit ok;
      int n;
      bit held_ok;

      vecs[0]  = '{1, 2, 4'h6};  vecs[1]  = '{0, 0, 4'h1};
      vecs[2]  = '{0, 1, 4'h2};  vecs[3]  = '{0, 2, 4'h3};
      vecs[4]  = '{0, 3, 4'hA};  vecs[5]  = '{1, 0, 4'h4};
      vecs[6]  = '{1, 1, 4'h5};  vecs[7]  = '{1, 3, 4'hB};
      vecs[8]  = '{2, 0, 4'h7};  vecs[9]  = '{2, 1, 4'h8};
      vecs[10] = '{2, 2, 4'h9};  vecs[11] = '{2, 3, 4'hC};
      vecs[12] = '{3, 0, 4'hE};  vecs[13] = '{3, 1, 4'h0};
      vecs[14] = '{3, 2, 4'hF};  vecs[15] = '{3, 3, 4'hD};

      // Reset and idle scan
      reset_n = 1'b0;
      cycles(3);
      chk("reset col", col, 4'b1110);
      chk("reset key", key, 4'h0);
      chk("reset key_valid", key_valid, 0);
      chk("reset key_held", key_held, 0);
      reset_n = 1'b1;
      held_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         chk("idle col", col, col_of((k / Scan) % 4));
         if (key_held) held_ok = 1'b0;
      end
      chk("idle key_held never", held_ok, 1);
      drain("idle");

      // Clean press of every key
      for (int i = 0; i < 16; i++) begin
         down = '0;
         down[vecs[i].r*4+vecs[i].c] = 1'b1;
         exp_q.push_back(vecs[i].code);
         wait_kv(ok);
         chk("press key", key, vecs[i].code);
         chk("press key_held", key_held, 1);
         chk("press col locked", col, col_of(vecs[i].c));
         cycles(5);
         chk("held key_held", key_held, 1);
         chk("held col", col, col_of(vecs[i].c));
         down = '0;
         wait_release(n);
         chk("release latency", n, Deb + 3);
         chk("resume col", col, col_of((vecs[i].c + 1) % 4));
         cycles(2);
         drain("press");
      end

      // Bounce during press debounce on (0,0)
      wait_col(0);
      down[0] = 1'b1; cycles(12);
      chk("bounce col locked", col, 4'b1110);
      down[0] = 1'b0; cycles(1);
      down[0] = 1'b1; cycles(5);
      down[0] = 1'b0; cycles(1);
      down[0] = 1'b1; cycles(5);
      down[0] = 1'b0; cycles(30);
      chk("bounce key_held", key_held, 0);
      drain("bounce");
      down[0] = 1'b1;
      exp_q.push_back(4'h1);
      wait_kv(ok);
      chk("bounce stable key", key, 4'h1);
      down = '0;
      wait_release(n);
      cycles(2);
      drain("bounce stable");

      // Reset during press debounce on (1,1)
      wait_col(1);
      down[5] = 1'b1;
      cycles(14);
      chk("mid-press key_held", key_held, 0);
      chk("mid-press col locked", col, 4'b1101);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid-press reset col", col, 4'b1110);
      chk("mid-press reset key", key, 4'h0);
      chk("mid-press reset key_held", key_held, 0);
      chk("mid-press reset key_valid", key_valid, 0);
      down = '0;
      cycles(2);
      reset_n = 1'b1;
      cycles(40);
      chk("post-reset key", key, 4'h0);
      drain("mid-press reset");

      // Release bounce and a ghost key while (3,1) is held
      down[13] = 1'b1;
      exp_q.push_back(4'h0);
      wait_kv(ok);
      cycles(5);
      down[13] = 1'b0; cycles(4);
      down[13] = 1'b1;
      down[3]  = 1'b1;
      held_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!key_held) held_ok = 1'b0;
      end
      chk("ghost key_held stays", held_ok, 1);
      chk("ghost key", key, 4'h0);
      chk("ghost col", col, 4'b1101);
      down = '0;
      wait_release(n);
      cycles(2);
      drain("ghost");

      // Long hold of (2,3)
      down[11] = 1'b1;
      exp_q.push_back(4'hC);
`ifdef KEYPAD_REPEAT_EN
      exp_q.push_back(4'hC);
      exp_q.push_back(4'hC);
`endif
      wait_kv(ok);
      cycles(89);
      down = '0;
      wait_release(n);
      cycles(2);
`ifdef KEYPAD_REPEAT_EN
      if (obs_q.size() == 3) begin
         chk("repeat +1 interval", obs_q[1].cyc - obs_q[0].cyc, Rep);
         chk("repeat +2 interval", obs_q[2].cyc - obs_q[0].cyc, 2 * Rep);
      end
`endif
      drain("repeat");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
